// File: rtl/rv_core_pkg.sv
// Shared RV32 core types: PC opsel encodings, PC FSM states,
// and immediate-extract helpers (J, B, I) returning 32-bit sign-extended values.
package rv_core_pkg;

  typedef enum logic [2:0] {
    OP_JAL  = 3'd0,
    OP_JALR = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_BLT  = 3'd4,
    OP_BGE  = 3'd5,
    OP_BLTU = 3'd6,
    OP_BGEU = 3'd7
  } pc_opsel_e;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

  localparam int FLUSH_CW = 3;

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12],
            ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7],
            ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

endpackage

// File: rtl/rv_pc_target.sv
// Redirect target, misalignment flag and redirect select (combinational).
// Ports: i_pc, i_rs1, i_instr, i_normal_op, i_pc_opsel, i_branch_taken
//        -> o_target, o_misalign, o_redirect. Macro: RV_PC_MISALIGN_TRAP_EN.
module rv_pc_target #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [31:0]     i_instr,
  input  logic            i_normal_op,
  input  logic [2:0]      i_pc_opsel,
  input  logic            i_branch_taken,
  output logic [XLEN-1:0] o_target,
  output logic            o_misalign,
  output logic            o_redirect
);
  import rv_core_pkg::*;

  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_raw;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_unused;

  assign w_imm_j  = XLEN'($signed(imm_j(i_instr)));
  assign w_imm_b  = XLEN'($signed(imm_b(i_instr)));
  assign w_imm_i  = XLEN'($signed(imm_i(i_instr)));
  assign w_unused = ^i_instr[6:0];

  assign w_is_jal  = (i_pc_opsel == OP_JAL);
  assign w_is_jalr = (i_pc_opsel == OP_JALR);

  always_comb begin
    w_raw = '0;
    unique case (1'b1)
      w_is_jal:  w_raw = i_pc + w_imm_j;
      w_is_jalr: w_raw = (i_rs1 + w_imm_i) & ~XLEN'(1);
      default:   w_raw = i_pc + w_imm_b;
    endcase
  end

  assign o_redirect = !i_normal_op &
                      (w_is_jal | w_is_jalr | i_branch_taken);

`ifdef RV_PC_MISALIGN_TRAP_EN
  assign o_target   = w_raw;
  assign o_misalign = w_raw[1];
`else
  // Without the trap, targets are word-aligned by force.
  assign o_target   = w_raw & ~XLEN'(3);
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/rv_pc_unit.sv
// IF-stage PC unit: RESET/RUN/HALT FSM, PC/EPC registers, flush counter.
// Ports: clk, rst_n, i_* controls/operands -> o_pc, o_link, o_flush,
// o_halt, o_trap_taken, o_epc. Macro: RV_PC_MISALIGN_TRAP_EN.
module rv_pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_enable,
  input  logic            i_stall,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_normal_op,
  input  logic [2:0]      i_pc_opsel,
  input  logic            i_branch_taken,
  input  logic            i_trap_req,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_link,
  output logic            o_flush,
  output logic            o_halt,
  output logic            o_trap_taken,
  output logic [XLEN-1:0] o_epc
);
  import rv_core_pkg::*;

  pc_state_e           r_state;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_epc;
  logic [FLUSH_CW-1:0] r_cnt;

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_seq;
  logic            w_misalign;
  logic            w_redirect;
  logic            w_trap;
  logic            w_go;

  rv_pc_target #(.XLEN(XLEN)) u_target (
    .i_pc           (r_pc),
    .i_rs1          (i_rs1),
    .i_instr        (i_instr),
    .i_normal_op    (i_normal_op),
    .i_pc_opsel     (i_pc_opsel),
    .i_branch_taken (i_branch_taken),
    .o_target       (w_target),
    .o_misalign     (w_misalign),
    .o_redirect     (w_redirect)
  );

  assign w_seq  = r_pc + XLEN'(4);
  assign w_go   = (r_state == ST_RUN) & i_enable & !i_stall;
  assign w_trap = i_trap_req | (w_redirect & w_misalign);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          // The reset-vector fetch is already out; step past it.
          if (i_enable) begin
            r_state <= ST_RUN;
            if (!i_stall) r_pc <= w_seq;
          end else begin
            r_state <= ST_HALT;
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            r_state <= ST_HALT;
          end else if (!i_stall) begin
            if (w_trap) begin
              r_pc  <= TRAP_VECTOR;
              r_epc <= r_pc;
              r_cnt <= FLUSH_CW'(FLUSH_CYCLES);
            end else if (w_redirect) begin
              r_pc  <= w_target;
              r_cnt <= FLUSH_CW'(FLUSH_CYCLES);
            end else begin
              r_pc <= w_seq;
              if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (i_enable) r_state <= ST_RUN;
        end
        default: r_state <= ST_RESET;
      endcase
    end
  end

  assign o_pc         = r_pc;
  assign o_link       = w_seq;
  assign o_epc        = r_epc;
  assign o_halt       = (r_state == ST_HALT);
  assign o_trap_taken = w_go & w_trap;
  assign o_flush      = (r_state == ST_RESET) |
                        ((r_state == ST_RUN) & (r_cnt != '0));

endmodule

// File: tb/tb_rv_pc_unit.sv
// Directed, table-driven bench for rv_pc_unit (FLUSH_CYCLES=2),
// plus hand-written reset-mid-flush and reset-into-HALT sequences.
module tb_rv_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, stall, normal_op, branch_taken, trap_req;
  logic [31:0] instr, rs1;
  logic [2:0]  pc_opsel;
  logic [31:0] pc, link, epc;
  logic        flush, halt, trap_taken;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (enable),
    .i_stall        (stall),
    .i_instr        (instr),
    .i_rs1          (rs1),
    .i_normal_op    (normal_op),
    .i_pc_opsel     (pc_opsel),
    .i_branch_taken (branch_taken),
    .i_trap_req     (trap_req),
    .o_pc           (pc),
    .o_link         (link),
    .o_flush        (flush),
    .o_halt         (halt),
    .o_trap_taken   (trap_taken),
    .o_epc          (epc)
  );

  typedef struct {
    logic        en, st, nm;
    logic [2:0]  op;
    logic        bt, tr;
    logic [31:0] ins, r1;
    logic [31:0] pc, epc;
    logic        fl, hl, tt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0,
            imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm);
    return {imm[11:0], 5'd0, 3'd0, 5'd0, 7'h67};
  endfunction

  task automatic add(
    input logic en, st, nm,
    input logic [2:0] op,
    input logic bt, tr,
    input logic [31:0] ins, r1, epc_x, pc_x,
    input logic fl, hl, tt
  );
    vec_t v;
    v.en = en; v.st = st; v.nm = nm; v.op = op;
    v.bt = bt; v.tr = tr; v.ins = ins; v.r1 = r1;
    v.pc = pc_x; v.epc = epc_x;
    v.fl = fl; v.hl = hl; v.tt = tt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] x, e;
  logic        tt18;

  initial begin
    rst_n = 1'b0; enable = 1'b1; stall = 1'b0; normal_op = 1'b1;
    pc_opsel = 3'd0; branch_taken = 1'b0; trap_req = 1'b0;
    instr = NOP; rs1 = '0;

`ifdef RV_PC_MISALIGN_TRAP_EN
    x = 32'h100; e = 32'h40; tt18 = 1'b1;
`else
    x = 32'h40;  e = 32'h0;  tt18 = 1'b0;
`endif

    for (int i = 0; i < 8; i++)
      add(1,0,1,0,0,0,NOP,0,0, 32'(i*4), i==0, 0,0);
    add(1,0,0,3'd0,0,0,enc_j(32'h40),0,0, 32'h20,0,0,0);
    add(1,0,1,0,0,0,NOP,0,0, 32'h60,1,0,0);
    add(1,0,1,0,0,0,NOP,0,0, 32'h64,1,0,0);
    add(1,0,0,3'd1,0,0,enc_i(32'h10),32'h1001,0, 32'h68,0,0,0);
    add(1,0,0,3'd0,0,0,enc_j(32'h30-32'h1010),0,0, 32'h1010,1,0,0);
    add(1,0,0,3'd3,1,0,enc_b(32'hFFFF_FFF8),0,0, 32'h30,1,0,0);
    add(1,0,1,0,0,0,NOP,0,0, 32'h28,1,0,0);
    add(1,0,1,0,0,0,NOP,0,0, 32'h2C,1,0,0);
    add(1,0,0,3'd2,0,0,enc_b(32'h10),0,0, 32'h30,0,0,0);
    add(1,0,0,3'd0,0,0,enc_j(32'hC),0,0, 32'h34,0,0,0);
    add(1,0,0,3'd0,0,0,enc_j(32'h2),0,0, 32'h40,1,0,tt18);
    add(1,0,1,0,0,0,NOP,0,e, x,1,0,0);
    for (int i = 0; i < 3; i++)
      add(1,1,0,3'd0,0,0,enc_j(32'h40),0,e, x+4,1,0,0);
    add(1,0,0,3'd0,0,0,enc_j(32'h40),0,e, x+4,1,0,0);
    add(1,0,1,0,0,0,NOP,0,e, x+32'h44,1,0,0);
    add(1,0,1,0,0,0,NOP,0,e, x+32'h48,1,0,0);
    add(1,0,0,3'd0,0,0,enc_j(32'h78-(x+32'h4C)),0,e, x+32'h4C,0,0,0);
    add(1,0,1,0,0,0,NOP,0,e, 32'h78,1,0,0);
    add(1,0,1,0,0,0,NOP,0,e, 32'h7C,1,0,0);
    add(0,0,1,0,0,0,NOP,0,e, 32'h80,0,0,0);
    add(0,0,1,0,0,1,NOP,0,e, 32'h80,0,1,0);
    add(0,0,1,0,0,1,NOP,0,e, 32'h80,0,1,0);
    add(1,0,1,0,0,1,NOP,0,e, 32'h80,0,1,0);
    add(1,0,1,0,0,1,NOP,0,e, 32'h80,0,0,1);
    add(1,0,1,0,0,0,NOP,0,32'h80, 32'h100,1,0,0);

    #12;
    chk("rst_pc",    pc,         32'h0);
    chk("rst_epc",   epc,        32'h0);
    chk("rst_tt",    32'(trap_taken), 32'h0);
    chk("rst_halt",  32'(halt),  32'h0);
    chk("rst_flush", 32'(flush), 32'h1);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en; stall = tbl[i].st;
      normal_op = tbl[i].nm; pc_opsel = tbl[i].op;
      branch_taken = tbl[i].bt; trap_req = tbl[i].tr;
      instr = tbl[i].ins; rs1 = tbl[i].r1;
      #2;
      chk($sformatf("r%0d_pc", i),    pc,   tbl[i].pc);
      chk($sformatf("r%0d_link", i),  link, tbl[i].pc + 32'h4);
      chk($sformatf("r%0d_flush", i), 32'(flush), 32'(tbl[i].fl));
      chk($sformatf("r%0d_halt", i),  32'(halt),  32'(tbl[i].hl));
      chk($sformatf("r%0d_tt", i),    32'(trap_taken), 32'(tbl[i].tt));
      chk($sformatf("r%0d_epc", i),   epc,  tbl[i].epc);
      @(posedge clk);
      #1;
    end

    // Mid-flush: reset must clear everything immediately.
    chk("mid_pc",    pc,         32'h104);
    chk("mid_flush", 32'(flush), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_pc",    pc,         32'h0);
    chk("arst_epc",   epc,        32'h0);
    chk("arst_flush", 32'(flush), 32'h1);
    chk("arst_halt",  32'(halt),  32'h0);

    // Leaving RESET with enable low goes to HALT.
    enable = 1'b0; trap_req = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rh_halt",  32'(halt),  32'h1);
    chk("rh_pc",    pc,         32'h0);
    chk("rh_flush", 32'(flush), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
